mod_match_type_run_encoder: RTL and testbench

Run-length encoder sitting directly downstream of the casex wildcard match classifier. It consumes the classifier's 2-bit match-type stream under a valid/ready handshake and collapses consecutive identical types into {type, run length} records on a registered valid/ready output. It also keeps a saturating per-type occurrence histogram for debug readback.

---
 rtl/mod_match_type_run_encoder.sv | 178 +++++++++++++++++
 tb/tb_mod_match_type_run_encoder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_match_type_run_encoder.sv
// Run-length encoder for the 2-bit match-type stream of the wildcard match
// classifier. Consecutive identical types are collapsed into {type, length}
// records on a registered valid/ready output. A saturating per-type
// occurrence histogram is kept alongside for debug readback.
module mod_match_type_run_encoder #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HIST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Match-type input stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_match_type,
  input  logic              in_flush,
  // Histogram control and readback
  input  logic              in_clear_hist,
  input  logic [1:0]        in_hist_sel,
  // Run record output stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_type,
  output logic [CNT_W-1:0]  out_run_len,
  output logic [HIST_W-1:0] out_hist_count
);

  // Longest run a single record can carry; longer runs are split here.
  localparam logic [CNT_W-1:0]  RunMax  = {CNT_W{1'b1}};
  localparam logic [HIST_W-1:0] HistMax = {HIST_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlushWait
  } state_e;

  state_e state_q, state_d;

  // Open run
  logic [1:0]       cur_type_q, cur_type_d;
  logic [CNT_W-1:0] cur_len_q, cur_len_d;

  // Output record register
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_type_q, out_type_d;
  logic [CNT_W-1:0] out_run_len_q, out_run_len_d;

  // Per-type occurrence counters, indexed by match type
  logic [3:0][HIST_W-1:0] hist_q, hist_d;

  logic             slot_free;
  logic             accept;
  logic             emit;
  logic [1:0]       emit_type;
  logic [CNT_W-1:0] emit_len;

  // Output slot can take a new record if empty or being drained this cycle.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
  end

  // Input handshake. Back-pressure applies to every beat in RUN, including
  // beats that would only extend the run, so in_ready stays a simple function.
  always_comb begin
    in_ready = !rst && !in_flush && (state_q != StFlushWait) &&
               ((state_q == StIdle) || slot_free);
    accept   = in_valid && in_ready;
  end

  // Run tracking FSM: next state, open run and record emission.
  always_comb begin
    state_d    = state_q;
    cur_type_d = cur_type_q;
    cur_len_d  = cur_len_q;
    emit       = 1'b0;
    emit_type  = cur_type_q;
    emit_len   = cur_len_q;

    case (state_q)
      StIdle: begin
        // A flush with no open run has nothing to close.
        if (accept) begin
          cur_type_d = in_match_type;
          cur_len_d  = CNT_W'(1);
          state_d    = StRun;
        end
      end

      StRun: begin
        if (in_flush) begin
          if (slot_free) begin
            emit      = 1'b1;
            cur_len_d = '0;
            state_d   = StIdle;
          end else begin
            state_d = StFlushWait;
          end
        end else if (accept) begin
          if ((in_match_type == cur_type_q) && (cur_len_q != RunMax)) begin
            cur_len_d = cur_len_q + CNT_W'(1);
          end else begin
            // Type change or full-length run: close it and start afresh.
            emit       = 1'b1;
            cur_type_d = in_match_type;
            cur_len_d  = CNT_W'(1);
          end
        end
      end

      StFlushWait: begin
        if (slot_free) begin
          emit      = 1'b1;
          cur_len_d = '0;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        cur_len_d = '0;
      end
    endcase
  end

  // Output record: a new emit overrides a same-cycle consume.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_type_d    = out_type_q;
    out_run_len_d = out_run_len_q;
    if (emit) begin
      out_valid_d   = 1'b1;
      out_type_d    = emit_type;
      out_run_len_d = emit_len;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Histogram update: clear beats a same-cycle increment; counters saturate.
  always_comb begin
    hist_d = hist_q;
    if (in_clear_hist) begin
      hist_d = '0;
    end else if (accept && (hist_q[in_match_type] != HistMax)) begin
      hist_d[in_match_type] = hist_q[in_match_type] + HIST_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cur_type_q    <= '0;
      cur_len_q     <= '0;
      out_valid_q   <= 1'b0;
      out_type_q    <= '0;
      out_run_len_q <= '0;
      hist_q        <= '0;
    end else begin
      state_q       <= state_d;
      cur_type_q    <= cur_type_d;
      cur_len_q     <= cur_len_d;
      out_valid_q   <= out_valid_d;
      out_type_q    <= out_type_d;
      out_run_len_q <= out_run_len_d;
      hist_q        <= hist_d;
    end
  end

  // Output drive and histogram readback mux.
  always_comb begin
    out_valid      = out_valid_q;
    out_type       = out_type_q;
    out_run_len    = out_run_len_q;
    out_hist_count = hist_q[in_hist_sel];
  end

endmodule

// File: tb/tb_mod_match_type_run_encoder.sv
// Bench for mod_match_type_run_encoder: directed scenarios on a default-size
// instance and a narrow instance (2-bit runs, 2-bit histogram), plus a random
// run against a behavioural model of the record stream and histogram.
module tb_mod_match_type_run_encoder;

  localparam int BigMax   = 255;
  localparam int SmallMax = 3;
  localparam int BigHist  = 65535;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_match_type;
  logic        in_flush;
  logic        in_clear_hist;
  logic [1:0]  in_hist_sel;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_type;
  logic [7:0]  out_run_len;
  logic [15:0] out_hist_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [1:0]  s_out_type;
  logic [1:0]  s_out_run_len;
  logic [1:0]  s_out_hist_count;

  int n_tests;
  int n_fail;

  mod_match_type_run_encoder #(.CNT_W(8), .HIST_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_match_type(in_match_type),
    .in_flush(in_flush), .in_clear_hist(in_clear_hist), .in_hist_sel(in_hist_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_run_len(out_run_len), .out_hist_count(out_hist_count)
  );

  mod_match_type_run_encoder #(.CNT_W(2), .HIST_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_match_type(in_match_type),
    .in_flush(in_flush), .in_clear_hist(in_clear_hist), .in_hist_sel(in_hist_sel),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_type(s_out_type),
    .out_run_len(s_out_run_len), .out_hist_count(s_out_hist_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_match_type = 2'd0; in_flush = 1'b0;
    in_clear_hist = 1'b0; in_hist_sel = 2'd0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_match_type = 2'd2; in_flush = 1'b0;
    in_clear_hist = 1'b0; out_ready = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_tests++; if (out_type !== 2'd0) begin n_fail++;
      $display("FAIL reset_out_type: got %0d expected 0", out_type); end
    n_tests++; if (out_run_len !== 8'd0) begin n_fail++;
      $display("FAIL reset_out_run_len: got %0d expected 0", out_run_len); end
    for (int s = 0; s < 4; s++) begin
      in_hist_sel = 2'(s);
      #1;
      n_tests++; if (out_hist_count !== 16'd0) begin n_fail++;
        $display("FAIL reset_hist%0d: got %0d expected 0", s, out_hist_count); end
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  // 10,10,10,11 then flush.
  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_match_type = 2'd2;
    tick(); tick(); tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL basic_no_early_record: got %0b expected 0", out_valid); end
    in_match_type = 2'd3;
    tick();
    in_valid = 1'b0;
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b1, 2'd2, 8'd3}) begin n_fail++;
      $display("FAIL basic_rec1: got v%0b t%0d l%0d expected v1 t2 l3",
               out_valid, out_type, out_run_len); end
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b1, 2'd3, 8'd1}) begin n_fail++;
      $display("FAIL basic_flush_rec: got v%0b t%0d l%0d expected v1 t3 l1",
               out_valid, out_type, out_run_len); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL basic_drained: got %0b expected 0", out_valid); end
    // Idle with a free slot must accept even under back-pressure.
    out_ready = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL basic_idle_ready: got %0b expected 1", in_ready); end
  endtask

  // n beats of type t then flush; records checked on both instances.
  task automatic test_runs(input int n, input int t);
    int bt[$], bl[$], st[$], sl[$];
    int cnt, len;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_match_type = 2'(t);
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_valid) begin bt.push_back(int'(out_type)); bl.push_back(int'(out_run_len)); end
      if (s_out_valid) begin st.push_back(int'(s_out_type)); sl.push_back(int'(s_out_run_len)); end
    end
    in_valid = 1'b0;
    in_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_flush = 1'b0;
      if (out_valid) begin bt.push_back(int'(out_type)); bl.push_back(int'(out_run_len)); end
      if (s_out_valid) begin st.push_back(int'(s_out_type)); sl.push_back(int'(s_out_run_len)); end
    end
    cnt = (n + BigMax - 1) / BigMax;
    n_tests++; if (bt.size() != cnt) begin n_fail++;
      $display("FAIL runs%0d_big_count: got %0d expected %0d", n, bt.size(), cnt); end
    for (int k = 0; k < cnt && k < bt.size(); k++) begin
      len = (k == cnt - 1) ? n - (cnt - 1) * BigMax : BigMax;
      n_tests++; if (bt[k] != t || bl[k] != len) begin n_fail++;
        $display("FAIL runs%0d_big_rec%0d: got t%0d l%0d expected t%0d l%0d",
                 n, k, bt[k], bl[k], t, len); end
    end
    cnt = (n + SmallMax - 1) / SmallMax;
    n_tests++; if (st.size() != cnt) begin n_fail++;
      $display("FAIL runs%0d_small_count: got %0d expected %0d", n, st.size(), cnt); end
    for (int k = 0; k < cnt && k < st.size(); k++) begin
      len = (k == cnt - 1) ? n - (cnt - 1) * SmallMax : SmallMax;
      n_tests++; if (st[k] != t || sl[k] != len) begin n_fail++;
        $display("FAIL runs%0d_small_rec%0d: got t%0d l%0d expected t%0d l%0d",
                 n, k, st[k], sl[k], t, len); end
    end
  endtask

  // Flush while the output slot is held by the consumer.
  task automatic test_flush_wait();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_match_type = 2'd3;
    tick();
    in_match_type = 2'd0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL fw_ready_slot_empty: got %0b expected 1", in_ready); end
    tick();
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b1, 2'd3, 8'd1}) begin n_fail++;
      $display("FAIL fw_first_rec: got v%0b t%0d l%0d expected v1 t3 l1",
               out_valid, out_type, out_run_len); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL fw_backpressure: got %0b expected 0", in_ready); end
    in_valid = 1'b0;
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL fw_wait_ready: got %0b expected 0", in_ready); end
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b1, 2'd3, 8'd1}) begin n_fail++;
      $display("FAIL fw_hold: got v%0b t%0d l%0d expected v1 t3 l1",
               out_valid, out_type, out_run_len); end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL fw_wait_ready_slot_free: got %0b expected 0", in_ready); end
    tick();
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b1, 2'd0, 8'd1}) begin n_fail++;
      $display("FAIL fw_flushed_rec: got v%0b t%0d l%0d expected v1 t0 l1",
               out_valid, out_type, out_run_len); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL fw_back_idle: got %0b expected 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL fw_drained: got %0b expected 0", out_valid); end
  endtask

  // Beat and flush in the same cycle: flush wins, beat not taken.
  task automatic test_valid_flush();
    do_reset();
    out_ready = 1'b1;
    in_hist_sel = 2'd1;
    in_valid = 1'b1;
    in_match_type = 2'd1;
    tick(); tick();
    in_flush = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL vf_ready: got %0b expected 0", in_ready); end
    tick();
    in_flush = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b1, 2'd1, 8'd2}) begin n_fail++;
      $display("FAIL vf_rec: got v%0b t%0d l%0d expected v1 t1 l2",
               out_valid, out_type, out_run_len); end
    n_tests++; if (out_hist_count !== 16'd2) begin n_fail++;
      $display("FAIL vf_hist: got %0d expected 2", out_hist_count); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL vf_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_hist();
    int exp_b[4];
    int exp_s[4];
    exp_b = '{2, 0, 0, 5};
    exp_s = '{2, 0, 0, 3};
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_match_type = 2'd3;
    repeat (5) tick();
    in_match_type = 2'd0;
    repeat (2) tick();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_hist_sel = 2'(s);
      #1;
      n_tests++; if (int'(out_hist_count) != exp_b[s]) begin n_fail++;
        $display("FAIL hist_big%0d: got %0d expected %0d", s, out_hist_count, exp_b[s]); end
      n_tests++; if (int'(s_out_hist_count) != exp_s[s]) begin n_fail++;
        $display("FAIL hist_small%0d: got %0d expected %0d", s, s_out_hist_count, exp_s[s]); end
    end
    in_valid = 1'b1;
    in_match_type = 2'd3;
    in_clear_hist = 1'b1;
    tick();
    in_clear_hist = 1'b0;
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_hist_sel = 2'(s);
      #1;
      n_tests++; if (out_hist_count !== 16'd0 || s_out_hist_count !== 2'd0) begin n_fail++;
        $display("FAIL hist_clear%0d: got %0d/%0d expected 0/0",
                 s, out_hist_count, s_out_hist_count); end
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_hist_sel = 2'd3;
    #1;
    n_tests++; if (out_hist_count !== 16'd1) begin n_fail++;
      $display("FAIL hist_after_clear: got %0d expected 1", out_hist_count); end
  endtask

  // Asynchronous reset with an open run and a pending record.
  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_match_type = 2'd2;
    tick();
    in_match_type = 2'd1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++;
      $display("FAIL rm_setup: got %0b expected 1", out_valid); end
    in_hist_sel = 2'd2;
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b0, 2'd0, 8'd0}) begin n_fail++;
      $display("FAIL rm_out_cleared: got v%0b t%0d l%0d expected v0 t0 l0",
               out_valid, out_type, out_run_len); end
    n_tests++; if (out_hist_count !== 16'd0) begin n_fail++;
      $display("FAIL rm_hist_cleared: got %0d expected 0", out_hist_count); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL rm_ready_in_reset: got %0b expected 0", in_ready); end
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_match_type = 2'd3;
    tick();
    in_match_type = 2'd0;
    tick();
    in_valid = 1'b0;
    n_tests++; if ({out_valid, out_type, out_run_len} !== {1'b1, 2'd3, 8'd1}) begin n_fail++;
      $display("FAIL rm_fresh_run: got v%0b t%0d l%0d expected v1 t3 l1",
               out_valid, out_type, out_run_len); end
  endtask

  // Random traffic against a transaction-level model of the encoder.
  task automatic test_random(input int cycles);
    bit m_open, m_fw, m_ov, slot_free, exp_rdy, acc, rec;
    int m_type, m_len, m_otype, m_olen, rt, rl, beat, prev;
    int m_hist[4];
    do_reset();
    m_open = 0; m_fw = 0; m_ov = 0; m_type = 0; m_len = 0; m_otype = 0; m_olen = 0;
    m_hist = '{0, 0, 0, 0};
    prev = 0;
    for (int c = 0; c < cycles; c++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      beat          = ($urandom_range(0, 3) != 0) ? prev : int'($urandom_range(0, 3));
      prev          = beat;
      in_match_type = 2'(beat);
      in_flush      = ($urandom_range(0, 19) == 0);
      in_clear_hist = ($urandom_range(0, 49) == 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      in_hist_sel   = 2'($urandom_range(0, 3));
      #1;
      slot_free = !m_ov || out_ready;
      exp_rdy   = !in_flush && !m_fw && (!m_open || slot_free);
      n_tests++; if (in_ready !== exp_rdy) begin n_fail++;
        $display("FAIL rnd_in_ready@%0d: got %0b expected %0b", c, in_ready, exp_rdy); end
      n_tests++; if (int'(out_hist_count) != m_hist[in_hist_sel]) begin n_fail++;
        $display("FAIL rnd_hist@%0d: got %0d expected %0d",
                 c, out_hist_count, m_hist[in_hist_sel]); end
      acc = in_valid && exp_rdy;
      rec = 0; rt = m_type; rl = m_len;
      if (m_fw) begin
        if (slot_free) begin rec = 1; m_open = 0; m_fw = 0; end
      end else if (m_open && in_flush) begin
        if (slot_free) begin rec = 1; m_open = 0; end
        else m_fw = 1;
      end else if (acc) begin
        if (!m_open) begin
          m_open = 1; m_type = beat; m_len = 1;
        end else if (beat == m_type && m_len < BigMax) begin
          m_len++;
        end else begin
          rec = 1; m_type = beat; m_len = 1;
        end
      end
      if (in_clear_hist) m_hist = '{0, 0, 0, 0};
      else if (acc && m_hist[beat] < BigHist) m_hist[beat]++;
      if (rec) begin m_ov = 1; m_otype = rt; m_olen = rl; end
      else if (m_ov && out_ready) m_ov = 0;
      tick();
      n_tests++; if (out_valid !== m_ov) begin n_fail++;
        $display("FAIL rnd_out_valid@%0d: got %0b expected %0b", c, out_valid, m_ov); end
      if (m_ov) begin
        n_tests++; if (int'(out_type) != m_otype || int'(out_run_len) != m_olen) begin n_fail++;
          $display("FAIL rnd_rec@%0d: got t%0d l%0d expected t%0d l%0d",
                   c, out_type, out_run_len, m_otype, m_olen); end
      end
    end
    in_valid = 1'b0; in_flush = 1'b0; in_clear_hist = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_match_type = 2'd0; in_flush = 1'b0;
    in_clear_hist = 1'b0; in_hist_sel = 2'd0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_runs(7, 1);
    test_runs(256, 2);
    test_flush_wait();
    test_valid_flush();
    test_hist();
    test_reset_mid();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
